// File: rtl/rv32_mem.sv
// rv32_mem: RV32 memory stage with IDLE/BUS FSM, byte-lane store steering and load extension.
// Define RV32_MEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them.
module rv32_mem (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        mem_read_en_in,
    input  logic        mem_write_en_in,
    input  logic [1:0]  mem_width_in,
    input  logic        mem_zero_extend_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_writeback_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rs2_value_in,
    output logic        stall_out,
    output logic [31:0] data_address_out,
    output logic        data_read_en_out,
    output logic        data_write_en_out,
    output logic [3:0]  data_write_mask_out,
    output logic [31:0] data_write_value_out,
    input  logic [31:0] data_read_value_in,
    input  logic        data_ready_in,
    output logic        valid_out,
    output logic [4:0]  rd_out,
    output logic        rd_writeback_out,
    output logic [31:0] rd_value_out,
    output logic        fault_out
);
    typedef enum logic {IDLE, BUS} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, rs2_q, rs2_d, value_q, value_d;
    logic [1:0]  width_q, width_d;
    logic        store_q, store_d, zext_q, zext_d, wb_q, wb_d;
    logic        valid_q, valid_d, wbo_q, wbo_d;
    logic [4:0]  rd_q, rd_d, rdo_q, rdo_d;
    logic        mem_op;
    logic [31:0] in_addr, shifted, load_value;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
    logic        fault_q, fault_d, misalign;
    assign misalign  = (mem_width_in == 2'b01) ? result_in[0] :
                       (mem_width_in == 2'b10) ? |result_in[1:0] : 1'b0;
    assign fault_out = fault_q;
`else
    assign fault_out = 1'b0;
`endif

    assign mem_op        = mem_read_en_in | mem_write_en_in;
    assign in_addr[31:2] = result_in[31:2];
    assign in_addr[1:0]  = (mem_width_in == 2'b00) ? result_in[1:0] :
                           (mem_width_in == 2'b01) ? {result_in[1], 1'b0} : 2'b00;

    // Loads extract the addressed lane first, then extend from its top bit.
    assign shifted    = data_read_value_in >> {addr_q[1:0], 3'b000};
    assign load_value = (width_q == 2'b00) ? {{24{~zext_q & shifted[7]}}, shifted[7:0]} :
                        (width_q == 2'b01) ? {{16{~zext_q & shifted[15]}}, shifted[15:0]} : shifted;

    assign stall_out            = (state_q == BUS);
    assign data_address_out     = {addr_q[31:2], 2'b00};
    assign data_read_en_out     = (state_q == BUS) & ~store_q;
    assign data_write_en_out    = (state_q == BUS) & store_q;
    assign data_write_mask_out  = (width_q == 2'b00) ? 4'b0001 << addr_q[1:0] :
                                  (width_q == 2'b01) ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
    assign data_write_value_out = rs2_q << {addr_q[1:0], 3'b000};
    assign valid_out            = valid_q;
    assign rd_out               = rdo_q;
    assign rd_writeback_out     = wbo_q;
    assign rd_value_out         = value_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rs2_d   = rs2_q;
        width_d = width_q;
        store_d = store_q;
        zext_d  = zext_q;
        wb_d    = wb_q;
        rd_d    = rd_q;
        valid_d = 1'b0;
        wbo_d   = 1'b0;
        rdo_d   = rdo_q;
        value_d = value_q;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
        fault_d = 1'b0;
`endif
        if (state_q == IDLE && valid_in) begin
            if (!mem_op) begin
                valid_d = 1'b1;
                rdo_d   = rd_in;
                wbo_d   = rd_writeback_in;
                value_d = result_in;
            end
`ifdef RV32_MEM_MISALIGN_TRAP_EN
            else if (misalign) begin
                valid_d = 1'b1;
                fault_d = 1'b1;
                rdo_d   = rd_in;
                value_d = 32'h0;
            end
`endif
            else begin
                state_d = BUS;
                addr_d  = in_addr;
                rs2_d   = rs2_value_in;
                width_d = mem_width_in;
                store_d = mem_write_en_in;
                zext_d  = mem_zero_extend_in;
                wb_d    = rd_writeback_in;
                rd_d    = rd_in;
            end
        end else if (state_q == BUS && data_ready_in) begin
            state_d = IDLE;
            valid_d = 1'b1;
            rdo_d   = rd_q;
            wbo_d   = ~store_q & wb_q;
            value_d = store_q ? 32'h0 : load_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            rs2_q   <= 32'h0;
            width_q <= 2'b00;
            store_q <= 1'b0;
            zext_q  <= 1'b0;
            wb_q    <= 1'b0;
            rd_q    <= 5'd0;
            valid_q <= 1'b0;
            wbo_q   <= 1'b0;
            rdo_q   <= 5'd0;
            value_q <= 32'h0;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rs2_q   <= rs2_d;
            width_q <= width_d;
            store_q <= store_d;
            zext_q  <= zext_d;
            wb_q    <= wb_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            wbo_q   <= wbo_d;
            rdo_q   <= rdo_d;
            value_q <= value_d;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
            fault_q <= fault_d;
`endif
        end
    end
endmodule

// File: tb/tb_rv32_mem.sv
// tb_rv32_mem: vector table plus scoreboard bench for rv32_mem, with reset and stall corner sequences.
module tb_rv32_mem;
    logic        clk = 1'b0;
    logic        reset, valid_in, mem_read_en_in, mem_write_en_in, mem_zero_extend_in;
    logic [1:0]  mem_width_in;
    logic [4:0]  rd_in, rd_out;
    logic        rd_writeback_in, stall_out, data_read_en_out, data_write_en_out;
    logic [31:0] result_in, rs2_value_in, data_address_out, data_write_value_out;
    logic [31:0] data_read_value_in, rd_value_out;
    logic [3:0]  data_write_mask_out;
    logic        data_ready_in, valid_out, rd_writeback_out, fault_out;

    rv32_mem dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
        .mem_width_in(mem_width_in), .mem_zero_extend_in(mem_zero_extend_in),
        .rd_in(rd_in), .rd_writeback_in(rd_writeback_in), .result_in(result_in),
        .rs2_value_in(rs2_value_in), .stall_out(stall_out),
        .data_address_out(data_address_out), .data_read_en_out(data_read_en_out),
        .data_write_en_out(data_write_en_out), .data_write_mask_out(data_write_mask_out),
        .data_write_value_out(data_write_value_out), .data_read_value_in(data_read_value_in),
        .data_ready_in(data_ready_in), .valid_out(valid_out), .rd_out(rd_out),
        .rd_writeback_out(rd_writeback_out), .rd_value_out(rd_value_out), .fault_out(fault_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rd_en; logic wr_en; logic [1:0] width; logic zext;
        logic [4:0] rd; logic wb; logic [31:0] result; logic [31:0] rs2; logic [31:0] rdata; int lat;
        logic [31:0] e_addr; logic e_re; logic e_we; logic [3:0] e_mask; logic [31:0] e_wval;
        logic [31:0] e_val; logic e_wb; logic e_fault; int e_stall;
    } vec_t;

    typedef struct { logic [4:0] rd; logic wb; logic [31:0] val; logic fault; } exp_t;

    exp_t exp_q[$];
    vec_t vecs[14];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(logic r, logic w, logic [1:0] wd, logic z, logic [4:0] rd, logic wb,
                                logic [31:0] res, logic [31:0] rs2, logic [31:0] rdat, int lat,
                                logic [31:0] ea, logic ere, logic ewe, logic [3:0] em, logic [31:0] ewv,
                                logic [31:0] ev, logic ewb, logic ef, int es);
        vec_t v;
        v.rd_en = r; v.wr_en = w; v.width = wd; v.zext = z; v.rd = rd; v.wb = wb;
        v.result = res; v.rs2 = rs2; v.rdata = rdat; v.lat = lat;
        v.e_addr = ea; v.e_re = ere; v.e_we = ewe; v.e_mask = em; v.e_wval = ewv;
        v.e_val = ev; v.e_wb = ewb; v.e_fault = ef; v.e_stall = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic retire(input string tag);
        exp_t e;
        check({tag, " valid_out"}, {31'h0, valid_out}, 32'h1);
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'h1, 32'h0);
        end else begin
            e = exp_q.pop_front();
            check({tag, " rd_out"}, {27'h0, rd_out}, {27'h0, e.rd});
            check({tag, " rd_writeback"}, {31'h0, rd_writeback_out}, {31'h0, e.wb});
            check({tag, " rd_value"}, rd_value_out, e.val);
            check({tag, " fault"}, {31'h0, fault_out}, {31'h0, e.fault});
        end
        check({tag, " bus_en_at_retire"}, {30'h0, data_read_en_out, data_write_en_out}, 32'h0);
    endtask

    task automatic drive(input vec_t v);
        valid_in = 1'b1; mem_read_en_in = v.rd_en; mem_write_en_in = v.wr_en;
        mem_width_in = v.width; mem_zero_extend_in = v.zext; rd_in = v.rd;
        rd_writeback_in = v.wb; result_in = v.result; rs2_value_in = v.rs2;
    endtask

    task automatic run(input vec_t v, input int idx);
        int cyc, stalls;
        exp_t e;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        drive(v);
        e.rd = v.rd; e.wb = v.e_wb; e.val = v.e_val; e.fault = v.e_fault;
        exp_q.push_back(e);
        @(posedge clk); #1;
        valid_in = 1'b0;
        cyc = 0;
        stalls = 0;
        while (!valid_out && cyc < 40) begin
            if (stall_out) begin
                stalls++;
                if (stalls == 1) begin
                    check({tag, " address"}, data_address_out, v.e_addr);
                    check({tag, " read_en"}, {31'h0, data_read_en_out}, {31'h0, v.e_re});
                    check({tag, " write_en"}, {31'h0, data_write_en_out}, {31'h0, v.e_we});
                    if (v.e_we) begin
                        check({tag, " write_mask"}, {28'h0, data_write_mask_out}, {28'h0, v.e_mask});
                        check({tag, " write_value"}, data_write_value_out, v.e_wval);
                    end
                end
                if (stalls == v.lat) begin
                    data_ready_in = 1'b1;
                    data_read_value_in = v.rdata;
                end
            end
            @(posedge clk); #1;
            data_ready_in = 1'b0;
            cyc++;
        end
        check({tag, " stall_cycles"}, stalls, v.e_stall);
        retire(tag);
        @(posedge clk); #1;
        check({tag, " pulse_end"}, {30'h0, valid_out, rd_writeback_out}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        exp_t e;
        vecs[0]  = mk(0,0,2'b10,0,5'd5,1,32'h1234,32'h0,32'h0,0, 0,0,0,4'h0,0, 32'h1234,1,0,0);
        vecs[1]  = mk(0,0,2'b01,1,5'd0,0,32'hDEADBEEF,32'h1,32'h0,0, 0,0,0,4'h0,0, 32'hDEADBEEF,0,0,0);
        vecs[2]  = mk(1,0,2'b00,0,5'd7,1,32'h103,32'h0,32'h80FFFFFF,2, 32'h100,1,0,4'h0,0, 32'hFFFFFF80,1,0,2);
        vecs[3]  = mk(0,1,2'b01,0,5'd0,1,32'h202,32'h0000ABCD,32'hFFFFFFFF,1, 32'h200,0,1,4'b1100,32'hABCD0000, 0,0,0,1);
        vecs[4]  = mk(1,0,2'b01,1,5'd8,1,32'h2,32'h0,32'h80010000,1, 32'h0,1,0,4'h0,0, 32'h00008001,1,0,1);
`ifdef RV32_MEM_MISALIGN_TRAP_EN
        vecs[5]  = mk(1,0,2'b10,0,5'd9,1,32'h5,32'h0,32'h11223344,1, 0,0,0,4'h0,0, 32'h0,0,1,0);
        vecs[13] = mk(1,0,2'b01,0,5'd14,1,32'h7,32'h0,32'h80001234,1, 0,0,0,4'h0,0, 32'h0,0,1,0);
`else
        vecs[5]  = mk(1,0,2'b10,0,5'd9,1,32'h5,32'h0,32'h11223344,1, 32'h4,1,0,4'h0,0, 32'h11223344,1,0,1);
        vecs[13] = mk(1,0,2'b01,0,5'd14,1,32'h7,32'h0,32'h80001234,1, 32'h4,1,0,4'h0,0, 32'hFFFF8000,1,0,1);
`endif
        vecs[6]  = mk(1,0,2'b01,0,5'd10,1,32'h0,32'h0,32'h1234F00F,1, 32'h0,1,0,4'h0,0, 32'hFFFFF00F,1,0,1);
        vecs[7]  = mk(1,0,2'b00,1,5'd11,1,32'h11,32'h0,32'h0000A500,3, 32'h10,1,0,4'h0,0, 32'h000000A5,1,0,3);
        vecs[8]  = mk(0,1,2'b00,0,5'd0,0,32'h3,32'hEE,32'hFFFFFFFF,1, 32'h0,0,1,4'b1000,32'hEE000000, 0,0,0,1);
        vecs[9]  = mk(0,1,2'b10,0,5'd0,0,32'h40,32'hCAFEBABE,32'hFFFFFFFF,2, 32'h40,0,1,4'b1111,32'hCAFEBABE, 0,0,0,2);
        vecs[10] = mk(1,1,2'b00,0,5'd0,1,32'h1,32'h55,32'hFFFFFFFF,1, 32'h0,0,1,4'b0010,32'h00005500, 0,0,0,1);
        vecs[11] = mk(1,0,2'b11,0,5'd12,1,32'h8,32'h0,32'h87654321,1, 32'h8,1,0,4'h0,0, 32'h87654321,1,0,1);
        vecs[12] = mk(1,0,2'b10,0,5'd13,1,32'h1000,32'h0,32'h0BADF00D,4, 32'h1000,1,0,4'h0,0, 32'h0BADF00D,1,0,4);

        reset = 1'b1; valid_in = 1'b1; mem_read_en_in = 1'b1; mem_write_en_in = 1'b0;
        mem_width_in = 2'b10; mem_zero_extend_in = 1'b0; rd_in = 5'd3; rd_writeback_in = 1'b1;
        result_in = 32'h44; rs2_value_in = 32'h0; data_read_value_in = 32'hDEADDEAD; data_ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset valid/wb/fault", {29'h0, valid_out, rd_writeback_out, fault_out}, 32'h0);
        check("reset stall/enables", {29'h0, stall_out, data_read_en_out, data_write_en_out}, 32'h0);
        check("reset rd_out", {27'h0, rd_out}, 32'h0);
        check("reset rd_value", rd_value_out, 32'h0);
        valid_in = 1'b0; data_ready_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) run(vecs[i], i);

        // Reset in the middle of a bus access abandons it.
        @(negedge clk);
        drive(mk(1,0,2'b10,0,5'd4,1,32'h10,32'h0,32'h0,1, 0,0,0,4'h0,0, 0,0,0,0));
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("midbus stall", {31'h0, stall_out}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midbus reset stall/enables", {29'h0, stall_out, data_read_en_out, data_write_en_out}, 32'h0);
        check("midbus reset valid/wb", {30'h0, valid_out, rd_writeback_out}, 32'h0);
        check("midbus reset rd_value", rd_value_out, 32'h0);
        data_ready_in = 1'b1; data_read_value_in = 32'h77777777;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post-reset ready ignored", {29'h0, valid_out, stall_out, data_read_en_out}, 32'h0);
        end
        data_ready_in = 1'b0;

        // valid_in held during BUS with a non-memory op must be ignored; address stays latched.
        @(negedge clk);
        drive(mk(1,0,2'b10,0,5'd3,1,32'h20,32'h0,32'h0,1, 0,0,0,4'h0,0, 0,0,0,0));
        e.rd = 5'd3; e.wb = 1'b1; e.val = 32'h13579BDF; e.fault = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        mem_read_en_in = 1'b0; result_in = 32'h999; rd_in = 5'd6;
        stalls = 0;
        for (int i = 0; i < 3 && !valid_out; i++) begin
            check("held address", data_address_out, 32'h20);
            check("held no early valid", {31'h0, valid_out}, 32'h0);
            stalls++;
            if (stalls == 3) begin
                data_ready_in = 1'b1; data_read_value_in = 32'h13579BDF; valid_in = 1'b0;
            end
            @(posedge clk); #1;
            data_ready_in = 1'b0;
        end
        retire("held_valid");
        @(posedge clk); #1;
        check("held pulse_end", {30'h0, valid_out, rd_writeback_out}, 32'h0);
        check("scoreboard drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rv32_mem.md
RV32_MEM -- requirements
Module: rv32_mem

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL: valid_in  in  1  execute stage presents an instruction this cycle.
REQ-004 SHALL: mem_read_en_in, mem_write_en_in  in  1 each  load / store request.
REQ-005 SHALL: mem_width_in  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-006 SHALL: mem_zero_extend_in  in  1  zero-extend load (else sign-extend).
REQ-007 SHALL: rd_in  in  5; rd_writeback_in  in  1  destination register and write flag.
REQ-008 SHALL: result_in  in  32  ALU result, which is the byte address for memory ops; rs2_value_in  in  32  store data.
REQ-009 SHALL: stall_out  out  1  upstream holds its outputs while high.
REQ-010 SHALL: data_address_out  out  32  word-aligned bus address; data_read_en_out, data_write_en_out  out  1 each.
REQ-011 SHALL: data_write_mask_out  out  4  byte lanes; data_write_value_out  out  32; data_read_value_in  in  32; data_ready_in  in  1  bus completion.
REQ-012 SHALL: valid_out  out  1; rd_out  out  5; rd_writeback_out  out  1; rd_value_out  out  32  writeback stage inputs.
REQ-013 SHALL: fault_out  out  1  misaligned access indication (RV32_MEM_MISALIGN_TRAP_EN only; tied 0 otherwise).

Function
REQ-014 SHALL: FSM states: IDLE, BUS.
REQ-015 SHALL: IDLE, valid_in with no memory op: next edge valid_out=1, rd_value_out=result_in, rd_out/rd_writeback_out copied (latency 1).
REQ-016 SHALL: IDLE, valid_in with memory op: latch all inputs and go to BUS; no valid_out that edge.
REQ-017 SHALL: if mem_read_en_in and mem_write_en_in are both high, treat the op as a store.
REQ-018 SHALL: in BUS, stall_out=1; read_en or write_en=1 per latched op; valid_in ignored.
REQ-019 SHALL: stall_out=0 in IDLE; all bus enables are 0 in IDLE.
REQ-020 SHALL: data_address_out={addr[31:2],2'b00}; address and enables derive only from latched registers, never combinationally from inputs.
REQ-021 SHALL: store mask: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word/reserved 4'b1111; data_write_value_out = rs2 shifted left by 8*lane offset.
REQ-022 SHALL: BUS with data_ready_in=1 at an edge: return to IDLE, valid_out=1 next cycle (minimum latency 2 from accept); no ready = hold indefinitely.
REQ-023 SHALL: load result: data_read_value_in shifted right by 8*addr[1:0], then byte/half sign- or zero-extended; word/reserved taken whole.
REQ-024 SHALL: store completion: rd_writeback_out=0, rd_value_out=0.
REQ-025 SHALL: valid_out is a single-cycle pulse per retired instruction; when it is 0, rd_writeback_out=0.

Reset
REQ-026 SHALL: reset forces state=IDLE and valid_out, rd_writeback_out, fault_out, stall_out and all bus enables to 0, with rd_out=0 and rd_value_out=0, one edge after assertion.
REQ-027 SHALL: reset during BUS abandons the access: no valid_out, and data_ready_in is ignored until a new access starts.

Configuration
REQ-028 SHALL: with RV32_MEM_MISALIGN_TRAP_EN defined, a misaligned access (half with addr[0]=1; word with addr[1:0]!=0) never enters BUS; next edge valid_out=1, fault_out=1, rd_writeback_out=0.
REQ-029 SHALL: without RV32_MEM_MISALIGN_TRAP_EN, offending low address bits are forced to natural alignment, the access proceeds normally, and fault_out is constant 0.

Verification
REQ-030 SHALL: non-memory op, result_in=0x1234, rd_in=5, wb=1 -> next cycle valid_out=1, rd_out=5, rd_value_out=0x1234.
REQ-031 SHALL: signed byte load, addr 0x103, read data 0x80FFFFFF, ready 2 cycles after BUS entry -> address 0x100, stall_out high 2 cycles, rd_value_out=0xFFFFFF80.
REQ-032 SHALL: half store, addr 0x202, rs2=0x0000ABCD -> mask 4'b1100, write_value 0xABCD0000, completion with rd_writeback_out=0.
REQ-033 SHALL: zero-extend half load, addr 0x2, read data 0x8001_0000 -> rd_value_out=0x00008001.
REQ-034 SHALL: reset asserted mid-BUS, then ready=1 -> no valid_out, enables 0, state IDLE.
REQ-035 SHALL: word load at addr 0x5 -> with macro: fault_out=1 and no bus enable; without macro: address 0x4 and a normal load.
